// File: rtl/eb_rd_ctrl_param.sv
// Read-side controller for the RX elastic buffer: binary/Gray read pointers, occupancy
// from the synchronised Gray write pointer, and SKP-based clock compensation.
module eb_rd_ctrl_param #(
  parameter int ADDR_WIDTH = 3,
  parameter int PTR_WIDTH  = ADDR_WIDTH + 1,
  parameter int LOW_WM     = 2,
  parameter int HIGH_WM    = 6
) (
  input  logic                  local_clk,
  input  logic                  local_rst,
  input  logic                  LTSSM_rst,
  input  logic [PTR_WIDTH-1:0]  r_gray_wptr,
  input  logic                  rd_en,
  input  logic                  head_is_skp,
  output logic                  empty,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [PTR_WIDTH-1:0]  gray_rptr,
  output logic [PTR_WIDTH-1:0]  occupancy,
  output logic                  skp_dropped,
  output logic                  skp_added,
  output logic                  underflow_err
);

  localparam logic [PTR_WIDTH-1:0] LOW_WM_P  = PTR_WIDTH'(LOW_WM);
  localparam logic [PTR_WIDTH-1:0] HIGH_WM_P = PTR_WIDTH'(HIGH_WM);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

  typedef enum logic [2:0] {
    DEC_HOLD,
    DEC_UNDERFLOW,
    DEC_DROP,
    DEC_ADD,
    DEC_NORMAL
  } dec_e;

  logic [PTR_WIDTH-1:0] r_rptr;
  logic [PTR_WIDTH-1:0] r_gray_rptr;
  logic                 r_ins_done;
  logic                 r_drop_last;
  logic                 r_underflow;

  logic [PTR_WIDTH-1:0] w_wbin;
  logic [PTR_WIDTH-1:0] w_occupancy;
  logic [PTR_WIDTH-1:0] w_rptr_next;
  logic [PTR_WIDTH-1:0] w_gray_next;
  logic                 w_empty;
  dec_e                 w_dec;

  // Gray-to-binary: each binary bit is the XOR of its Gray bit and every bit above it.
  always_comb begin
    for (int i = 0; i < PTR_WIDTH; i++) begin
      w_wbin[i] = ^(r_gray_wptr >> i);
    end
  end

  assign w_occupancy = w_wbin - r_rptr;
  assign w_empty     = (r_gray_rptr == r_gray_wptr);

  // LTSSM_rst suppresses every decision so no pulse escapes in the clearing cycle.
  always_comb begin
    // NOTE: default first so every path assigns w_dec and no latch is inferred.
    w_dec = DEC_HOLD;
    if (!LTSSM_rst && rd_en) begin
      if (w_empty) begin
        w_dec = DEC_UNDERFLOW;
      end else if (head_is_skp && (w_occupancy >= HIGH_WM_P) && !r_drop_last) begin
        w_dec = DEC_DROP;
      end else if (head_is_skp && (w_occupancy <= LOW_WM_P) && !r_ins_done) begin
        w_dec = DEC_ADD;
      end else begin
        w_dec = DEC_NORMAL;
      end
    end
  end

  assign w_rptr_next = ((w_dec == DEC_DROP) || (w_dec == DEC_NORMAL)) ? r_rptr + PTR_ONE : r_rptr;
  assign w_gray_next = w_rptr_next ^ (w_rptr_next >> 1);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge local_clk or negedge local_rst) begin
    if (!local_rst) begin
      r_rptr      <= '0;
      r_gray_rptr <= '0;
      r_ins_done  <= 1'b0;
      r_drop_last <= 1'b0;
      r_underflow <= 1'b0;
    end else if (LTSSM_rst) begin
      r_rptr      <= '0;
      r_gray_rptr <= '0;
      r_ins_done  <= 1'b0;
      r_drop_last <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_rptr      <= w_rptr_next;
      r_gray_rptr <= w_gray_next;
      case (w_dec)
        DEC_UNDERFLOW: r_underflow <= 1'b1;
        DEC_DROP:      r_drop_last <= 1'b1;
        DEC_ADD:       r_ins_done  <= 1'b1;
        DEC_NORMAL: begin
          r_ins_done  <= 1'b0;
          r_drop_last <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign empty         = w_empty;
  assign occupancy     = w_occupancy;
  assign rd_valid      = (w_dec == DEC_ADD) || (w_dec == DEC_NORMAL);
  assign skp_dropped   = (w_dec == DEC_DROP);
  assign skp_added     = (w_dec == DEC_ADD);
  assign raddr         = r_rptr[ADDR_WIDTH-1:0];
  assign gray_rptr     = r_gray_rptr;
  assign underflow_err = r_underflow;

endmodule
